// File: rtl/matrix_frame_buffer.sv
// Double-buffered 64x32 3-bit-per-pixel frame store: game logic draws into the back bank,
// the scan driver reads upper/lower half-panel pixel pairs from the front bank.
module matrix_frame_buffer #(
    parameter int COL_BITS = 6,
    parameter int ROW_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [COL_BITS-1:0] wr_x,
    input  logic [ROW_BITS-1:0] wr_y,
    input  logic [2:0]          wr_rgb,
    input  logic                clr_req,
    output logic                clr_busy,
    input  logic                swap_req,
    output logic                swap_ack,
    input  logic                frame_done,
    input  logic                rd_en,
    input  logic [ROW_BITS-2:0] rd_row,
    input  logic [COL_BITS-1:0] rd_col,
    output logic                rd_valid,
    output logic [2:0]          rgb0,
    output logic [2:0]          rgb1,
    output logic                front_sel
);

    localparam int ADDR_BITS = COL_BITS + ROW_BITS;
    localparam int DEPTH     = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = {ADDR_BITS{1'b1}};
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    typedef enum logic [0:0] {
        SW_IDLE = 1'b0,
        SW_PEND = 1'b1
    } sw_state_t;

    logic [2:0] bank0_r [DEPTH];
    logic [2:0] bank1_r [DEPTH];

    clr_state_t             clr_state_r;
    clr_state_t             clr_state_s;
    logic [ADDR_BITS-1:0]   clr_addr_r;
    logic [ADDR_BITS-1:0]   clr_addr_s;
    logic                   clr_busy_r;

    sw_state_t              sw_state_r;
    sw_state_t              sw_state_s;
    logic                   swap_fire_s;
    logic                   swap_ack_r;
    logic                   front_sel_r;

    logic                   mem_we_s;
    logic [ADDR_BITS-1:0]   mem_waddr_s;
    logic [2:0]             mem_wdata_s;

    logic [ADDR_BITS-1:0]   rd_addr0_s;
    logic [ADDR_BITS-1:0]   rd_addr1_s;
    logic                   rd_valid_r;
    logic [2:0]             rgb0_r;
    logic [2:0]             rgb1_r;

    assign clr_busy  = clr_busy_r;
    assign swap_ack  = swap_ack_r;
    assign front_sel = front_sel_r;
    assign rd_valid  = rd_valid_r;
    assign rgb0      = rgb0_r;
    assign rgb1      = rgb1_r;

    assign rd_addr0_s = {1'b0, rd_row, rd_col};
    assign rd_addr1_s = {1'b1, rd_row, rd_col};

    // Clear sequencer: one back-bank address per cycle, stops after the last address.
    always_comb begin
        clr_state_s = clr_state_r;
        clr_addr_s  = clr_addr_r;
        case (clr_state_r)
            CLR_IDLE: begin
                if (clr_req) begin
                    clr_state_s = CLR_RUN;
                    clr_addr_s  = {ADDR_BITS{1'b0}};
                end else begin
                    clr_state_s = CLR_IDLE;
                end
            end
            CLR_RUN: begin
                clr_addr_s = clr_addr_r + ADDR_ONE;
                if (clr_addr_r == LAST_ADDR) begin
                    clr_state_s = CLR_IDLE;
                end else begin
                    clr_state_s = CLR_RUN;
                end
            end
            default: begin
                clr_state_s = CLR_IDLE;
                clr_addr_s  = {ADDR_BITS{1'b0}};
            end
        endcase
    end

    // Clear state and busy flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_state_r <= CLR_IDLE;
            clr_addr_r  <= {ADDR_BITS{1'b0}};
            clr_busy_r  <= 1'b0;
        end else begin
            clr_state_r <= clr_state_s;
            clr_addr_r  <= clr_addr_s;
            clr_busy_r  <= (clr_state_s == CLR_RUN);
        end
    end

    // Swap arbiter: a pending request waits for a frame boundary with no clear in flight.
    always_comb begin
        sw_state_s  = sw_state_r;
        swap_fire_s = 1'b0;
        case (sw_state_r)
            SW_IDLE: begin
                if (swap_req) begin
                    sw_state_s = SW_PEND;
                end else begin
                    sw_state_s = SW_IDLE;
                end
            end
            SW_PEND: begin
                if (frame_done && !clr_busy_r) begin
                    swap_fire_s = 1'b1;
                    sw_state_s  = SW_IDLE;
                end else begin
                    sw_state_s  = SW_PEND;
                end
            end
            default: begin
                sw_state_s  = SW_IDLE;
                swap_fire_s = 1'b0;
            end
        endcase
    end

    // Swap state, bank select and acknowledge registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_state_r  <= SW_IDLE;
            swap_ack_r  <= 1'b0;
            front_sel_r <= 1'b0;
        end else begin
            sw_state_r  <= sw_state_s;
            swap_ack_r  <= swap_fire_s;
            front_sel_r <= front_sel_r ^ swap_fire_s;
        end
    end

    // Back-bank write port mux; a running clear owns the port and drops pixel writes.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = {wr_y, wr_x};
        mem_wdata_s = wr_rgb;
        if (clr_busy_r) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_addr_r;
            mem_wdata_s = 3'b000;
        end else if (wr_en) begin
            mem_we_s    = 1'b1;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Bank storage write; the target is the bank not currently displayed (pre-swap on a swap edge).
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            if (front_sel_r) begin
                bank0_r[mem_waddr_s] <= mem_wdata_s;
            end else begin
                bank1_r[mem_waddr_s] <= mem_wdata_s;
            end
        end
    end

    // Front-bank pixel-pair read; data holds while no request is presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_r <= 1'b0;
            rgb0_r     <= 3'b000;
            rgb1_r     <= 3'b000;
        end else begin
            rd_valid_r <= rd_en;
            if (rd_en) begin
                if (front_sel_r) begin
                    rgb0_r <= bank1_r[rd_addr0_s];
                    rgb1_r <= bank1_r[rd_addr1_s];
                end else begin
                    rgb0_r <= bank0_r[rd_addr0_s];
                    rgb1_r <= bank0_r[rd_addr1_s];
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_frame_buffer.sv
// Directed bench for matrix_frame_buffer: clear, fill, swap, tear-free display and reset behaviour.
module tb_matrix_frame_buffer;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [5:0] wr_x;
    logic [4:0] wr_y;
    logic [2:0] wr_rgb;
    logic       clr_req;
    logic       clr_busy;
    logic       swap_req;
    logic       swap_ack;
    logic       frame_done;
    logic       rd_en;
    logic [3:0] rd_row;
    logic [5:0] rd_col;
    logic       rd_valid;
    logic [2:0] rgb0;
    logic [2:0] rgb1;
    logic       front_sel;

    int vectors;
    int miscompares;
    int n;
    int acks;
    int bad;

    matrix_frame_buffer #(.COL_BITS(6), .ROW_BITS(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_rgb     (wr_rgb),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .frame_done (frame_done),
        .rd_en      (rd_en),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_valid   (rd_valid),
        .rgb0       (rgb0),
        .rgb1       (rgb1),
        .front_sel  (front_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b0; wr_en = 1'b0; wr_x = 6'd0; wr_y = 5'd0; wr_rgb = 3'b000;
        clr_req = 1'b0; swap_req = 1'b0; frame_done = 1'b0;
        rd_en = 1'b0; rd_row = 4'd0; rd_col = 6'd0;
        #12;
        chk("rst_front_sel", {31'd0, front_sel}, 32'd0);
        chk("rst_swap_ack",  {31'd0, swap_ack},  32'd0);
        chk("rst_clr_busy",  {31'd0, clr_busy},  32'd0);
        chk("rst_rd_valid",  {31'd0, rd_valid},  32'd0);
        chk("rst_rgb0",      {29'd0, rgb0},      32'd0);
        chk("rst_rgb1",      {29'd0, rgb1},      32'd0);
        rst = 1'b1;
        tick();

        // Clear bank 1; a write at clear cycle 500, a re-request, and a swap with frame_done during it.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0; acks = 0;
        while (clr_busy === 1'b1 && n < 3000) begin
            n++;
            wr_en      = (n == 500);
            wr_x       = 6'd1; wr_y = 5'd1; wr_rgb = 3'b101;
            clr_req    = (n == 1000);
            swap_req   = (n == 10);
            frame_done = (n == 10) || (n == 20);
            tick();
            if (swap_ack === 1'b1) acks++;
        end
        wr_en = 1'b0; clr_req = 1'b0; swap_req = 1'b0; frame_done = 1'b0;
        chk("clr_busy_cycles", n, 32'd2048);
        chk("clr_no_ack", acks, 32'd0);
        chk("clr_front_sel", {31'd0, front_sel}, 32'd0);

        // Fill two pixels, then the deferred swap completes on the next frame_done.
        wr_en = 1'b1; wr_x = 6'd5; wr_y = 5'd3;  wr_rgb = 3'b100; tick();
        wr_x = 6'd5; wr_y = 5'd19; wr_rgb = 3'b010; tick();
        wr_en = 1'b0;
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        frame_done = 1'b1; tick(); frame_done = 1'b0;
        chk("fill_swap_ack", {31'd0, swap_ack}, 32'd1);
        chk("fill_front_sel", {31'd0, front_sel}, 32'd1);
        tick();
        chk("fill_ack_pulse", {31'd0, swap_ack}, 32'd0);

        rd_en = 1'b1; rd_row = 4'd3; rd_col = 6'd5; tick(); rd_en = 1'b0;
        chk("rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("rd_rgb0", {29'd0, rgb0}, 32'd4);
        chk("rd_rgb1", {29'd0, rgb1}, 32'd2);
        tick();
        chk("rd_idle_valid", {31'd0, rd_valid}, 32'd0);
        chk("rd_hold_rgb0", {29'd0, rgb0}, 32'd4);
        rd_en = 1'b1; rd_row = 4'd1; rd_col = 6'd1; tick(); rd_en = 1'b0;
        chk("drop_rgb0", {29'd0, rgb0}, 32'd0);
        chk("drop_rgb1", {29'd0, rgb1}, 32'd0);

        // Tear-free: pixel (0,0)=7 in bank 0, swap pending for 100 frames-free cycles.
        wr_en = 1'b1; wr_x = 6'd0; wr_y = 5'd0; wr_rgb = 3'b111; tick(); wr_en = 1'b0;
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        rd_en = 1'b1; rd_row = 4'd0; rd_col = 6'd0;
        bad = 0; acks = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rgb0 !== 3'b000) bad++;
            if (swap_ack === 1'b1) acks++;
        end
        chk("tear_old_value", bad, 32'd0);
        chk("tear_no_ack", acks, 32'd0);
        frame_done = 1'b1; tick(); frame_done = 1'b0;
        chk("tear_swap_ack", {31'd0, swap_ack}, 32'd1);
        chk("tear_front_sel", {31'd0, front_sel}, 32'd0);
        chk("tear_swap_cycle_rd", {29'd0, rgb0}, 32'd0);
        tick();
        chk("tear_new_value", {29'd0, rgb0}, 32'd7);
        rd_en = 1'b0;

        // Three merged swap requests, two frame_done pulses, then an idle frame_done.
        for (int i = 0; i < 3; i++) begin
            swap_req = 1'b1; tick(); swap_req = 1'b0; tick();
        end
        acks = 0;
        for (int i = 0; i < 2; i++) begin
            frame_done = 1'b1; tick(); frame_done = 1'b0;
            if (swap_ack === 1'b1) acks++;
            tick();
            if (swap_ack === 1'b1) acks++;
        end
        chk("merge_acks", acks, 32'd1);
        chk("merge_front_sel", {31'd0, front_sel}, 32'd1);
        acks = 0;
        frame_done = 1'b1; tick(); frame_done = 1'b0;
        if (swap_ack === 1'b1) acks++;
        tick();
        if (swap_ack === 1'b1) acks++;
        chk("idle_fd_acks", acks, 32'd0);
        chk("idle_fd_front_sel", {31'd0, front_sel}, 32'd1);
        rd_en = 1'b1; rd_row = 4'd3; rd_col = 6'd5; tick();
        chk("bank1_again_rgb0", {29'd0, rgb0}, 32'd4);

        // Async reset mid-clear with a swap pending and bank 1 displayed.
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        repeat (50) tick();
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        chk("pre_rst_busy", {31'd0, clr_busy}, 32'd1);
        chk("pre_rst_valid", {31'd0, rd_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_front_sel", {31'd0, front_sel}, 32'd0);
        chk("arst_clr_busy", {31'd0, clr_busy}, 32'd0);
        chk("arst_swap_ack", {31'd0, swap_ack}, 32'd0);
        chk("arst_rd_valid", {31'd0, rd_valid}, 32'd0);
        rd_en = 1'b0;
        #2 rst = 1'b1;
        tick();
        acks = 0;
        frame_done = 1'b1; tick(); frame_done = 1'b0;
        if (swap_ack === 1'b1) acks++;
        repeat (2) begin
            tick();
            if (swap_ack === 1'b1) acks++;
        end
        chk("post_rst_no_ack", acks, 32'd0);
        chk("post_rst_front_sel", {31'd0, front_sel}, 32'd0);
        chk("post_rst_clr_busy", {31'd0, clr_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
